// File: rtl/avl_mem_pkg.sv
// Shared types and helpers for the Avalon-MM on-chip memory responder.
package avl_mem_pkg;

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StStall,
        StAccept
    } state_e;

    // Bits needed for a counter that runs 0..n-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/avl_rd_pipe.sv
// Fixed-latency read-return shift register; data stages only load on valid so the
// output data holds its last returned value between pulses.
module avl_rd_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o
);

    logic [LATENCY-1:0] valid_q;
    logic [DATA_W-1:0]  data_q [LATENCY];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid_i;
            if (in_valid_i) begin
                data_q[0] <= in_data_i;
            end
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid_o = valid_q[LATENCY-1];
    assign out_data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/avl_mem_responder.sv
// Avalon-MM slave emulating the LPDDR2 controller local interface with on-chip RAM:
// init-done delay, programmable wait states and fixed read latency.
module avl_mem_responder
    import avl_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = 27,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MEM_AW       = 10,
    parameter int unsigned INIT_CYCLES  = 16,
    parameter int unsigned WAIT_CYCLES  = 2,
    parameter int unsigned READ_LATENCY = 3
) (
    input  logic              iCLK,
    input  logic              iRST,
    output logic              local_init_done,
    input  logic [ADDR_W-1:0] avl_address,
    input  logic [DATA_W-1:0] avl_writedata,
    input  logic              avl_read,
    input  logic              avl_write,
    input  logic              avl_burstbegin,
    output logic              avl_waitrequest_n,
    output logic              avl_readdatavalid,
    output logic [DATA_W-1:0] avl_readdata,
    output logic              protocol_err
);

    localparam int unsigned InitW    = cnt_w(INIT_CYCLES);
    localparam int unsigned WaitW    = cnt_w(WAIT_CYCLES);
    localparam int unsigned InitLast = INIT_CYCLES - 1;
    localparam int unsigned WaitLast = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    state_e             state_q;
    logic [InitW-1:0]   init_cnt_q;
    logic [WaitW-1:0]   wait_cnt_q;
    logic               init_done_q;
    logic               wrn_q;
    logic               err_q;
    logic [DATA_W-1:0]  mem_q [2**MEM_AW];

    logic [MEM_AW-1:0]  idx;
    logic [DATA_W-1:0]  rd_data;
    logic               cmd;
    logic               accept;
    logic               wr_fire;
    logic               rd_fire;
    logic               viol;
    logic               unused_addr_hi;

    // Upper address bits alias onto the RAM; they are deliberately ignored.
    assign unused_addr_hi = ^avl_address[ADDR_W-1:MEM_AW];

    assign idx     = avl_address[MEM_AW-1:0];
    assign rd_data = mem_q[idx];
    assign cmd     = avl_read | avl_write;
    assign accept  = (state_q == StAccept);
    assign wr_fire = accept & avl_write;
    assign rd_fire = accept & avl_read & ~avl_write;
    assign viol    = accept & ((avl_read & avl_write) | ~cmd | (avl_burstbegin != cmd));

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= StInit;
            init_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            init_done_q <= 1'b0;
            wrn_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                StInit: begin
                    if (init_cnt_q == InitW'(InitLast)) begin
                        init_done_q <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                    end
                end
                StIdle: begin
                    if (cmd) begin
                        if (WAIT_CYCLES == 0) begin
                            state_q <= StAccept;
                            wrn_q   <= 1'b1;
                        end else begin
                            state_q    <= StStall;
                            wait_cnt_q <= '0;
                        end
                    end
                end
                StStall: begin
                    if (wait_cnt_q == WaitW'(WaitLast)) begin
                        state_q <= StAccept;
                        wrn_q   <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                StAccept: begin
                    state_q <= StIdle;
                    wrn_q   <= 1'b0;
                    if (viol) begin
                        err_q <= 1'b1;
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    // RAM is never reset so contents survive a controller reset.
    always_ff @(posedge iCLK) begin
        if (wr_fire) begin
            mem_q[idx] <= avl_writedata;
        end
    end

    avl_rd_pipe #(
        .DATA_W (DATA_W),
        .LATENCY(READ_LATENCY)
    ) u_rd_pipe (
        .clk_i      (iCLK),
        .rst_i      (iRST),
        .in_valid_i (rd_fire),
        .in_data_i  (rd_data),
        .out_valid_o(avl_readdatavalid),
        .out_data_o (avl_readdata)
    );

    assign local_init_done   = init_done_q;
    assign avl_waitrequest_n = wrn_q;
    assign protocol_err      = err_q;

endmodule

// File: tb/tb_avl_mem_responder.sv
// Self-checking bench: default-parameter instance for timing/error/reset checks and a
// WAIT_CYCLES=0, READ_LATENCY=8 instance for pipelined reads.
module tb_avl_mem_responder;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge iCLK) cyc++;

    logic        a_done, a_wrn, a_rdv, a_err, a_read, a_write, a_bb;
    logic [26:0] a_addr;
    logic [31:0] a_wdata, a_rdata;
    logic        b_done, b_wrn, b_rdv, b_err, b_read, b_write, b_bb;
    logic [26:0] b_addr;
    logic [31:0] b_wdata, b_rdata;

    avl_mem_responder u_dut_a (
        .iCLK             (iCLK),
        .iRST             (iRST),
        .local_init_done  (a_done),
        .avl_address      (a_addr),
        .avl_writedata    (a_wdata),
        .avl_read         (a_read),
        .avl_write        (a_write),
        .avl_burstbegin   (a_bb),
        .avl_waitrequest_n(a_wrn),
        .avl_readdatavalid(a_rdv),
        .avl_readdata     (a_rdata),
        .protocol_err     (a_err)
    );

    avl_mem_responder #(
        .WAIT_CYCLES (0),
        .READ_LATENCY(8)
    ) u_dut_b (
        .iCLK             (iCLK),
        .iRST             (iRST),
        .local_init_done  (b_done),
        .avl_address      (b_addr),
        .avl_writedata    (b_wdata),
        .avl_read         (b_read),
        .avl_write        (b_write),
        .avl_burstbegin   (b_bb),
        .avl_waitrequest_n(b_wrn),
        .avl_readdatavalid(b_rdv),
        .avl_readdata     (b_rdata),
        .protocol_err     (b_err)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        bit          wr;
        logic [26:0] addr;
        logic [31:0] data;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    logic [31:0] a_last = '0;
    logic [31:0] b_last = '0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Read-return monitor / scoreboard for both instances.
    always @(negedge iCLK) begin
        if (iRST) begin
            a_last = '0;
            b_last = '0;
        end else begin
            if (a_rdv) begin
                if (qa.size() == 0) begin
                    chk1("a_unexpected_valid", 1'b1, 1'b0);
                end else begin
                    ea = qa.pop_front();
                    chk32("a_readdata", a_rdata, ea.data);
                    chk32("a_read_latency", cyc, ea.due);
                end
                a_last = a_rdata;
            end else begin
                chk32("a_readdata_hold", a_rdata, a_last);
            end
            if (b_rdv) begin
                if (qb.size() == 0) begin
                    chk1("b_unexpected_valid", 1'b1, 1'b0);
                end else begin
                    eb = qb.pop_front();
                    chk32("b_readdata", b_rdata, eb.data);
                    chk32("b_read_latency", cyc, eb.due);
                end
                b_last = b_rdata;
            end else begin
                chk32("b_readdata_hold", b_rdata, b_last);
            end
        end
    end

    // Called #1 after the edge that releases reset; holds a write during INIT.
    task automatic init_check();
        a_write = 1'b1;
        a_bb    = 1'b1;
        a_addr  = 27'h7;
        for (int i = 0; i <= 16; i++) begin
            @(negedge iCLK);
            chk1("init_done", a_done, i == 16);
            chk1("init_waitreq_n", a_wrn, 1'b0);
            chk1("init_protocol_err", a_err, 1'b0);
        end
        a_write = 1'b0;
        a_bb    = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge iCLK);
        #2 iRST = 1'b1;
        #1;
        chk1("rst_init_done", a_done, 1'b0);
        chk1("rst_waitreq_n", a_wrn, 1'b0);
        chk1("rst_readdatavalid", a_rdv, 1'b0);
        chk32("rst_readdata", a_rdata, 32'h0);
        chk1("rst_protocol_err", a_err, 1'b0);
        qa.delete();
        qb.delete();
        a_read  = 1'b0;
        a_write = 1'b0;
        a_bb    = 1'b0;
        repeat (3) @(posedge iCLK);
        #1 iRST = 1'b0;
        init_check();
    endtask

    // One command on instance A; for a clean read, data is the expected return value.
    task automatic a_cmd(input bit rd, input bit wr, input bit bb, input logic [26:0] addr,
                         input logic [31:0] data, input bit withdraw);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        @(posedge iCLK);
        #1;
        a_read  = rd;
        a_write = wr;
        a_bb    = bb;
        a_addr  = addr;
        a_wdata = data;
        while (!got && n < 20) begin
            @(negedge iCLK);
            if (a_wrn) begin
                got = 1'b1;
            end else begin
                if (withdraw && n == 1) begin
                    a_read  = 1'b0;
                    a_write = 1'b0;
                end
                n++;
            end
        end
        if (!got) begin
            chk1("a_accept_timeout", 1'b0, 1'b1);
        end else begin
            chk32("a_accept_delay", n, 3);
            if (rd && !wr && !withdraw) begin
                qa.push_back('{data: data, due: cyc + 3});
            end
        end
        @(posedge iCLK);
        #1;
        a_read  = 1'b0;
        a_write = 1'b0;
        a_bb    = 1'b0;
        @(negedge iCLK);
        chk1("a_accept_width", a_wrn, 1'b0);
    endtask

    task automatic b_wait(output int acc);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(negedge iCLK);
            if (b_wrn) got = 1'b1;
            else n++;
        end
        if (!got) chk1("b_accept_timeout", 1'b0, 1'b1);
        else chk32("b_accept_delay", n, 1);
        acc = cyc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   acc;
        int   prev;
        vecs[0] = '{wr: 1'b1, addr: 27'h005, data: 32'hDEADBEEF};
        vecs[1] = '{wr: 1'b0, addr: 27'h005, data: 32'hDEADBEEF};
        vecs[2] = '{wr: 1'b1, addr: 27'h400, data: 32'h12345678};
        vecs[3] = '{wr: 1'b0, addr: 27'h000, data: 32'h12345678};
        vecs[4] = '{wr: 1'b1, addr: 27'h3FF, data: 32'hA5A5A5A5};
        vecs[5] = '{wr: 1'b0, addr: 27'h7FF, data: 32'hA5A5A5A5};
        vecs[6] = '{wr: 1'b1, addr: 27'h005, data: 32'h0BADF00D};
        vecs[7] = '{wr: 1'b0, addr: 27'h005, data: 32'h0BADF00D};
        vecs[8] = '{wr: 1'b0, addr: 27'h3FF, data: 32'hA5A5A5A5};

        {a_read, a_write, a_bb} = 3'b000;
        {b_read, b_write, b_bb} = 3'b000;
        a_addr  = '0;
        a_wdata = '0;
        b_addr  = '0;
        b_wdata = '0;

        repeat (2) @(posedge iCLK);
        #1;
        chk1("por_init_done", a_done, 1'b0);
        chk1("por_waitreq_n", a_wrn, 1'b0);
        chk1("por_readdatavalid", a_rdv, 1'b0);
        chk1("por_protocol_err", a_err, 1'b0);
        iRST = 1'b0;
        init_check();

        foreach (vecs[i]) begin
            a_cmd(!vecs[i].wr, vecs[i].wr, 1'b1, vecs[i].addr, vecs[i].data, 1'b0);
        end
        repeat (6) @(negedge iCLK);
        chk1("table_no_error", a_err, 1'b0);
        chk32("table_drained", qa.size(), 0);

        // Read and write together: write happens, read dropped.
        a_cmd(1'b1, 1'b1, 1'b1, 27'h010, 32'h11111111, 1'b0);
        repeat (6) @(negedge iCLK);
        chk1("rdwr_error", a_err, 1'b1);
        do_reset();
        a_cmd(1'b1, 1'b0, 1'b1, 27'h010, 32'h11111111, 1'b0);
        repeat (6) @(negedge iCLK);
        chk1("rdwr_clean_after_reset", a_err, 1'b0);

        // Read withdrawn before acceptance.
        a_cmd(1'b1, 1'b0, 1'b1, 27'h005, 32'h0, 1'b1);
        repeat (6) @(negedge iCLK);
        chk1("withdraw_error", a_err, 1'b1);
        do_reset();

        // Burstbegin low on a write: error, write still done.
        a_cmd(1'b0, 1'b1, 1'b0, 27'h020, 32'h22222222, 1'b0);
        repeat (6) @(negedge iCLK);
        chk1("burstbegin_error", a_err, 1'b1);
        do_reset();
        a_cmd(1'b1, 1'b0, 1'b1, 27'h020, 32'h22222222, 1'b0);
        repeat (6) @(negedge iCLK);

        // Reset while a read is in flight: the return is lost, RAM survives.
        a_cmd(1'b1, 1'b0, 1'b1, 27'h005, 32'h0BADF00D, 1'b0);
        do_reset();
        a_cmd(1'b1, 1'b0, 1'b1, 27'h005, 32'h0BADF00D, 1'b0);
        repeat (6) @(negedge iCLK);
        chk1("after_reset_no_error", a_err, 1'b0);

        // Instance B: three reads in flight at two-cycle spacing.
        for (int k = 1; k <= 3; k++) begin
            @(posedge iCLK);
            #1;
            b_write = 1'b1;
            b_bb    = 1'b1;
            b_addr  = 27'(k);
            b_wdata = 32'hB0 + 32'(k);
            b_wait(acc);
            @(posedge iCLK);
            #1;
            b_write = 1'b0;
            b_bb    = 1'b0;
        end
        @(posedge iCLK);
        #1;
        b_read = 1'b1;
        b_bb   = 1'b1;
        b_addr = 27'd1;
        prev   = 0;
        for (int k = 1; k <= 3; k++) begin
            b_wait(acc);
            if (k > 1) chk32("b_accept_spacing", acc - prev, 2);
            prev = acc;
            qb.push_back('{data: 32'hB0 + 32'(k), due: acc + 8});
            @(posedge iCLK);
            #1;
            if (k < 3) begin
                b_addr = 27'(k + 1);
            end else begin
                b_read = 1'b0;
                b_bb   = 1'b0;
            end
        end
        repeat (12) @(negedge iCLK);
        chk32("a_pending_reads", qa.size(), 0);
        chk32("b_pending_reads", qb.size(), 0);
        chk1("b_no_error", b_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
